// File: rtl/logic_result_stage.sv
// logic_result_stage
//   Registered result stage behind the 16-bit bitwise logic units. The stage
//   selects one unit result per transaction by opcode, derives zero/parity/sign
//   flags, and buffers {data, op, flags} in a 2-entry FIFO with a valid/ready
//   handshake toward writeback. It also keeps a wrapping count of delivered
//   results for debug.
//
// Optional feature macro: LOGIC_POPCNT_EN
//   When defined, each entry also stores the number of ones in its result,
//   presented on out_popcnt.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (push = in_valid && in_ready)
//   in_op               result select: 0=AND 1=OR 2=XOR 3=NOT-A
//   and_in .. nota_in   logic unit results
//   out_valid/out_ready downstream handshake (pop = out_valid && out_ready)
//   out_data, out_op    head entry result and opcode
//   out_zero/parity/sign head entry flags
//   out_popcnt          head entry ones count (LOGIC_POPCNT_EN only)
//   occupancy           FIFO entry count, 0..2
//   done_count          delivered-result count, wraps

module logic_result_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [WIDTH-1:0]         and_in,
  input  logic [WIDTH-1:0]         or_in,
  input  logic [WIDTH-1:0]         xor_in,
  input  logic [WIDTH-1:0]         nota_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_op,
  output logic                     out_zero,
  output logic                     out_parity,
  output logic                     out_sign,
  output logic [1:0]               occupancy,
`ifdef LOGIC_POPCNT_EN
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt,
`endif
  output logic [CNT_W-1:0]         done_count
);

  localparam int unsigned PW = $clog2(WIDTH + 1);

  // Entry storage
  logic [WIDTH-1:0] data_q   [2];
  logic [1:0]       op_q     [2];
  logic             zero_q   [2];
  logic             parity_q [2];
  logic             sign_q   [2];
`ifdef LOGIC_POPCNT_EN
  logic [PW-1:0]    popcnt_q [2];
`endif

  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q;

  logic             push, pop;
  logic [WIDTH-1:0] sel;
  logic             sel_zero, sel_parity, sel_sign;
  logic             head_idx;

  // Handshake signals depend only on registered occupancy.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    sel = and_in;
    unique case (in_op)
      2'd0: sel = and_in;
      2'd1: sel = or_in;
      2'd2: sel = xor_in;
      2'd3: sel = nota_in;
      default: sel = and_in;
    endcase
  end

  assign sel_zero   = (sel == '0);
  assign sel_parity = ^sel;
  assign sel_sign   = sel[WIDTH-1];

`ifdef LOGIC_POPCNT_EN
  logic [PW-1:0] sel_popcnt;

  always_comb begin
    sel_popcnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sel_popcnt = sel_popcnt + PW'(sel[i]);
    end
  end
`endif

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]   <= '0;
        op_q[i]     <= '0;
        zero_q[i]   <= 1'b0;
        parity_q[i] <= 1'b0;
        sign_q[i]   <= 1'b0;
`ifdef LOGIC_POPCNT_EN
        popcnt_q[i] <= '0;
`endif
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q]   <= sel;
        op_q[wr_ptr_q]     <= in_op;
        zero_q[wr_ptr_q]   <= sel_zero;
        parity_q[wr_ptr_q] <= sel_parity;
        sign_q[wr_ptr_q]   <= sel_sign;
`ifdef LOGIC_POPCNT_EN
        popcnt_q[wr_ptr_q] <= sel_popcnt;
`endif
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        cnt_q    <= cnt_q + 1'b1;
      end
      occ_q <= occ_d;
    end
  end

  // When empty, the slot behind the read pointer holds the last delivered
  // entry (all zeros after reset), so presenting it keeps out_* at their last
  // value. Nothing can overwrite that slot until a push makes the FIFO non-empty.
  assign head_idx = out_valid ? rd_ptr_q : ~rd_ptr_q;

  assign out_data   = data_q[head_idx];
  assign out_op     = op_q[head_idx];
  assign out_zero   = zero_q[head_idx];
  assign out_parity = parity_q[head_idx];
  assign out_sign   = sign_q[head_idx];
`ifdef LOGIC_POPCNT_EN
  assign out_popcnt = popcnt_q[head_idx];
`endif
  assign occupancy  = occ_q;
  assign done_count = cnt_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// Scoreboard bench for logic_result_stage: the driver pushes the expected
// entry for each accepted transaction; the monitor compares the head on every
// cycle and retires entries on pops.
module tb_logic_result_stage;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [15:0] and_in = '0, or_in = '0, xor_in = '0, nota_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_op;
  logic        out_zero, out_parity, out_sign;
  logic [1:0]  occupancy;
  logic [7:0]  done_count;
`ifdef LOGIC_POPCNT_EN
  logic [4:0]  out_popcnt;
`endif

  logic_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .and_in     (and_in),
    .or_in      (or_in),
    .xor_in     (xor_in),
    .nota_in    (nota_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_sign   (out_sign),
    .occupancy  (occupancy),
`ifdef LOGIC_POPCNT_EN
    .out_popcnt (out_popcnt),
`endif
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  op;
    logic        zero;
    logic        parity;
    logic        sign;
    int          ones;
  } exp_t;

  exp_t       sb[$];
  exp_t       last;
  logic [7:0] exp_done;
  int         pops_total;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Reference: pick the unit result, then derive flags by counting ones.
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] o, input logic [15:0] x,
                                 input logic [15:0] n);
    exp_t e;
    logic [15:0] r;
    int k;
    if (op == 2'd0) r = a;
    else if (op == 2'd1) r = o;
    else if (op == 2'd2) r = x;
    else r = n;
    k = 0;
    for (int i = 0; i < 16; i++) if (r[i]) k++;
    e.data   = r;
    e.op     = op;
    e.zero   = (r == 16'd0);
    e.parity = (k % 2) == 1;
    e.sign   = (r >= 16'h8000);
    e.ones   = k;
    return e;
  endfunction

  function automatic exp_t zero_entry();
    exp_t e;
    e.data = '0; e.op = '0; e.zero = 1'b0; e.parity = 1'b0; e.sign = 1'b0; e.ones = 0;
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, "_data"}, int'(out_data), int'(e.data));
    chk({tag, "_op"}, int'(out_op), int'(e.op));
    chk({tag, "_zero"}, int'(out_zero), int'(e.zero));
    chk({tag, "_parity"}, int'(out_parity), int'(e.parity));
    chk({tag, "_sign"}, int'(out_sign), int'(e.sign));
`ifdef LOGIC_POPCNT_EN
    chk({tag, "_popcnt"}, int'(out_popcnt), e.ones);
`endif
  endtask

  // Monitor: queue contents mirror the DUT entries at every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      last = zero_entry();
      exp_done = '0;
    end else begin
      chk("occupancy", int'(occupancy), sb.size());
      chk("in_ready", int'(in_ready), int'(sb.size() != 2));
      chk("out_valid", int'(out_valid), int'(sb.size() != 0));
      chk("done_count", int'(done_count), int'(exp_done));
      if (sb.size() != 0) begin
        cmp_out("head", sb[0]);
        if (out_valid && out_ready) begin
          last = sb.pop_front();
          exp_done = exp_done + 8'd1;
          pops_total++;
        end
      end else begin
        cmp_out("hold", last);
      end
    end
  end

  // One cycle of stimulus; the accepted transaction is recorded just after
  // the falling edge so the monitor sees queue state matching the DUT.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] o, input logic [15:0] x, input logic [15:0] n,
                       input logic rdy);
    @(posedge clk);
    #1;
    in_valid = v; in_op = op; and_in = a; or_in = o; xor_in = x; nota_in = n;
    out_ready = rdy;
    @(negedge clk);
    #1;
    if (!reset && in_valid && in_ready) sb.push_back(model(in_op, and_in, or_in, xor_in, nota_in));
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, rdy);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    pops_total = 0;
    last = zero_entry();
    exp_done = '0;
    do_reset();
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_done_count", int'(done_count), 0);

    // Single AND transaction delivered immediately.
    cycle(1'b1, 2'd0, 16'h0F0F, 16'h1111, 16'h2222, 16'h3333, 1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("t1_done_count", int'(done_count), 1);

    // Fill to two entries while stalled; the third request must be refused.
    cycle(1'b1, 2'd2, 16'h1234, 16'h5678, 16'h8001, 16'h9ABC, 1'b0);
    cycle(1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    cycle(1'b1, 2'd1, 16'h0, 16'hAAAA, 16'h0, 16'h0, 1'b0);
    chk("t2_full_in_ready", int'(in_ready), 0);
    chk("t2_head_data", int'(out_data), 16'h8001);
    chk("t2_head_sign", int'(out_sign), 1);

    // Pop from full with in_valid held: no push that cycle.
    cycle(1'b1, 2'd1, 16'h0, 16'hAAAA, 16'h0, 16'h0, 1'b1);
    idle(1'b0);
    chk("t3_in_ready", int'(in_ready), 1);
    chk("t3_head_zero", int'(out_zero), 1);
    chk("t3_head_op", int'(out_op), 3);

    // Simultaneous push and pop at occupancy 1.
    cycle(1'b1, 2'd1, 16'h0, 16'h0007, 16'h0, 16'h0, 1'b1);
    idle(1'b0);
    chk("t4_occupancy", int'(occupancy), 1);
    chk("t4_head_data", int'(out_data), 16'h0007);
    chk("t4_head_parity", int'(out_parity), 1);

`ifdef LOGIC_POPCNT_EN
    cycle(1'b1, 2'd1, 16'h0, 16'hFFFF, 16'h0, 16'h0, 1'b0);
    idle(1'b1);
    chk("popcnt_ffff_after_pop", int'(out_popcnt), 16);
`endif

    // Asynchronous reset with two entries held, away from any clock edge.
    cycle(1'b1, 2'd2, 16'h0, 16'h0, 16'hC3C3, 16'h0, 1'b0);
    cycle(1'b1, 2'd0, 16'h5A5A, 16'h0, 16'h0, 16'h0, 1'b0);
    idle(1'b0);
    chk("t5_pre_occupancy", int'(occupancy), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_out_valid", int'(out_valid), 0);
    chk("t5_async_occupancy", int'(occupancy), 0);
    chk("t5_async_done_count", int'(done_count), 0);
    do_reset();

    // Counter wrap: 256 pops from a clean reset.
    pops_total = 0;
    for (int i = 0; i < 400 && pops_total < 256; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 1'b1);
    end
    chk("wrap_pops", pops_total, 256);
    idle(1'b0);
    chk("wrap_done_count", int'(done_count), 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a, o, x, n;
      a = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      o = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      x = 16'($urandom);
      n = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, o, x, n,
            1'($urandom_range(0, 2) != 0));
    end
    // Drain.
    for (int i = 0; i < 10; i++) idle(1'b1);
    chk("drain_occupancy", int'(occupancy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_result_stage.md
Name: logic_result_stage

Overview:
- Registered result stage directly downstream of the 16-bit bitwise logic units (AND, OR, XOR, NOT-A).
- Selects one unit's output per transaction by opcode and derives zero, parity and sign flags.
- Buffers results in a 2-entry FIFO with a valid/ready handshake toward the writeback/register-file stage.
- Also keeps a wrap-around count of delivered results for debug.

Parameters:
- WIDTH, 16, data width of every logic-unit result and of out_data.
- CNT_W, 8, width of the delivered-result counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a transaction this cycle.
- in_ready  output  1  stage can accept a transaction this cycle.
- in_op  input  2  result select: 0=AND, 1=OR, 2=XOR, 3=NOT-A.
- and_in  input  WIDTH  output of the AND unit.
- or_in  input  WIDTH  output of the OR unit.
- xor_in  input  WIDTH  output of the XOR unit.
- nota_in  input  WIDTH  output of the NOT-A unit.
- out_valid  output  1  head FIFO entry is valid.
- out_ready  input  1  downstream accepts the head entry this cycle.
- out_data  output  WIDTH  selected result of the head entry.
- out_op  output  2  opcode of the head entry.
- out_zero  output  1  head result is all zeros.
- out_parity  output  1  XOR-reduction of the head result (1 = odd number of ones).
- out_sign  output  1  MSB of the head result.
- occupancy  output  2  FIFO entry count, 0..2.
- done_count  output  CNT_W  number of results delivered, wraps.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, mid-transfer included):
  - occupancy=0, read/write pointers=0, done_count=0.
  - out_valid=0, out_data=0, out_op=0, out_zero=0, out_parity=0, out_sign=0, in_ready=1 once reset deasserts.
  - Any transaction in flight is discarded.
- Handshakes:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - in_ready = (occupancy != 2), purely from registered state, with no combinational path from out_ready.
- Capture:
  - On a push, data = mux(in_op) of the four inputs.
  - Flags are computed from that selected word in the same cycle.
  - {data, op, zero, parity, sign} is written into the entry at the write pointer.
- Latency: a push in cycle N makes the entry visible at the output in cycle N+1 (out_valid=1 if it is the head). No combinational input-to-output path.
- Outputs:
  - out_* reflect the head entry whenever out_valid=1.
  - When empty, out_valid=0 and out_* hold their last value (0 after reset).
  - out_* must stay stable while out_valid=1 and out_ready=0.
- Pointers are 1 bit each and toggle on push/pop respectively (2-entry wrap).
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged. This is legal at occupancy 1; at 0 no pop is possible; at 2 no push is possible since in_ready=0.
- Full (2): in_ready=0 and in_valid is ignored. A pop in that cycle frees a slot, but in_ready only rises the next cycle.
- Empty (0): out_valid=0 and out_ready is ignored.
- done_count increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
- in_op is decoded fully; all four codes are legal.

Optional Feature:
- Macro: LOGIC_POPCNT_EN.
- When defined:
  - Adds output port out_popcnt, width $clog2(WIDTH+1) (5 bits for WIDTH=16): the number of ones in the head result.
  - Computed at push time and stored per entry.
  - Resets to 0 and follows the same stability rules as out_data.
- When undefined: the port, the storage and the logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then push op=0 with and_in=16'h0F0F, out_ready=1 -> next cycle out_valid=1, out_data=16'h0F0F, out_zero=0, out_parity=0, out_sign=0; after the pop done_count=1.
- Push op=2 with xor_in=16'h8001, then op=3 with nota_in=16'h0000, out_ready=0 -> occupancy=2, in_ready=0; head holds 16'h8001, sign=1, parity=0 while stalled. A third in_valid is not accepted.
- From full, assert out_ready for one cycle while in_valid=1 -> one pop, no push that cycle, in_ready=1 next cycle. The second entry then appears with data 16'h0000, zero=1, op=3.
- Occupancy 1 with simultaneous push (op=1, or_in=16'h0007) and pop -> occupancy stays 1. Next head is 16'h0007, parity=1. No entry is lost or duplicated.
- Assert reset mid-stream with occupancy 2 -> out_valid=0, occupancy=0, done_count=0 immediately, without waiting for a clock edge.
- With LOGIC_POPCNT_EN defined: push op=1 with or_in=16'hFFFF -> out_popcnt=16. Perform 256 pops with CNT_W=8 -> done_count wraps to 0.
